sw_stopwatch_counter: RTL and testbench

- Downstream timing core of the stopwatch. Consumes the 2-bit SW_S_MODE from the switch-transfer stage (00 reset, 01 run, 10 stop) and keeps BCD time MM:SS.cc.
- Runs on the 1 kHz system clock, with a prescaler producing the 1/100 s tick.
- Adds a lap-freeze function: the display can be held while counting continues internally.
- Feeds the 7-segment display driver.

---
 rtl/sw_stopwatch_counter_if.sv | 27 ++
 rtl/sw_stopwatch_counter.sv | 152 +++++++++++++++
 tb/tb_sw_stopwatch_counter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sw_stopwatch_counter_if.sv
// Mode/lap inputs and BCD display outputs shared between the stopwatch
// timing core and whoever drives and reads it.
interface sw_stopwatch_counter_if;
    logic [1:0] SW_S_MODE;
    logic       SW_L;
    logic [3:0] CS_ONES;
    logic [3:0] CS_TENS;
    logic [3:0] SEC_ONES;
    logic [3:0] SEC_TENS;
    logic [3:0] MIN_ONES;
    logic [3:0] MIN_TENS;
    logic       RUNNING;
    logic       LAP_HOLD;
    logic       OVERFLOW;

    modport master (
        output SW_S_MODE, SW_L,
        input  CS_ONES, CS_TENS, SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS,
        input  RUNNING, LAP_HOLD, OVERFLOW
    );

    modport slave (
        input  SW_S_MODE, SW_L,
        output CS_ONES, CS_TENS, SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS,
        output RUNNING, LAP_HOLD, OVERFLOW
    );
endinterface

// File: rtl/sw_stopwatch_counter.sv
// Stopwatch timing core: prescaled centisecond tick, BCD MM:SS.cc carry chain,
// lap freeze latch and sticky wrap flag.
module sw_stopwatch_counter #(
    parameter int CLK_PER_TICK = 10,
    parameter int PRE_W        = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    sw_stopwatch_counter_if.slave sw
);

    // Digit index 0 is CS_ONES, index 5 is MIN_TENS.
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_TICK - 1);
    localparam logic [5:0][3:0]  DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    logic [PRE_W-1:0] pre_r;
    logic [PRE_W-1:0] pre_next_s;
    logic [5:0][3:0]  live_r;
    logic [5:0][3:0]  live_next_s;
    logic [5:0][3:0]  lap_r;
    logic [5:0][3:0]  disp_s;
    logic [6:0]       carry_s;
    logic             lap_hold_r;
    logic             overflow_r;
    logic             running_r;
    logic             sw_l_prev_r;
    logic             run_mode_s;
    logic             stop_mode_s;
    logic             clear_mode_s;
    logic             tick_s;
    logic             wrap_s;
    logic             lap_edge_s;

    // One BCD digit stage: returns {carry_out, next_digit}. Anything at or
    // above the digit maximum rolls to zero, so no out-of-range value survives.
    function automatic logic [4:0] bcd_step(input logic [3:0] d,
                                            input logic [3:0] max_d,
                                            input logic       cin);
        logic [4:0] res;
        if (!cin) begin
            res = {1'b0, d};
        end else if (d >= max_d) begin
            res = {1'b1, 4'd0};
        end else begin
            res = {1'b0, d + 4'd1};
        end
        return res;
    endfunction

    // Decode the upstream mode; 11 falls into the clear case with 00.
    always_comb begin
        run_mode_s  = 1'b0;
        stop_mode_s = 1'b0;
        case (sw.SW_S_MODE)
            2'b01: run_mode_s = 1'b1;
            2'b10: stop_mode_s = 1'b1;
            default: begin
                run_mode_s  = 1'b0;
                stop_mode_s = 1'b0;
            end
        endcase
    end

    assign clear_mode_s = ~run_mode_s & ~stop_mode_s;
    assign lap_edge_s   = sw.SW_L & ~sw_l_prev_r & ~clear_mode_s;

    // Prescaler advance and centisecond tick generation.
    always_comb begin
        tick_s     = 1'b0;
        pre_next_s = pre_r;
        if (run_mode_s) begin
            if (pre_r >= PRE_LAST) begin
                tick_s     = 1'b1;
                pre_next_s = {PRE_W{1'b0}};
            end else begin
                pre_next_s = pre_r + PRE_W'(1);
            end
        end else begin
            tick_s     = 1'b0;
            pre_next_s = pre_r;
        end
    end

    // Ripple the tick through all six digits in one cycle.
    always_comb begin
        carry_s     = 7'd0;
        live_next_s = live_r;
        carry_s[0]  = tick_s;
        {carry_s[1], live_next_s[0]} = bcd_step(live_r[0], DIGIT_MAX[0], carry_s[0]);
        {carry_s[2], live_next_s[1]} = bcd_step(live_r[1], DIGIT_MAX[1], carry_s[1]);
        {carry_s[3], live_next_s[2]} = bcd_step(live_r[2], DIGIT_MAX[2], carry_s[2]);
        {carry_s[4], live_next_s[3]} = bcd_step(live_r[3], DIGIT_MAX[3], carry_s[3]);
        {carry_s[5], live_next_s[4]} = bcd_step(live_r[4], DIGIT_MAX[4], carry_s[4]);
        {carry_s[6], live_next_s[5]} = bcd_step(live_r[5], DIGIT_MAX[5], carry_s[5]);
    end

    assign wrap_s = carry_s[6];

    // Timing state, lap latch and status flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pre_r       <= {PRE_W{1'b0}};
            live_r      <= 24'd0;
            lap_r       <= 24'd0;
            lap_hold_r  <= 1'b0;
            overflow_r  <= 1'b0;
            running_r   <= 1'b0;
            sw_l_prev_r <= 1'b0;
        end else begin
            sw_l_prev_r <= sw.SW_L;
            running_r   <= run_mode_s;
            if (clear_mode_s) begin
                pre_r      <= {PRE_W{1'b0}};
                live_r     <= 24'd0;
                lap_r      <= 24'd0;
                lap_hold_r <= 1'b0;
                overflow_r <= 1'b0;
            end else begin
                if (run_mode_s) begin
                    pre_r  <= pre_next_s;
                    live_r <= live_next_s;
                    if (wrap_s) begin
                        overflow_r <= 1'b1;
                    end
                end
                // The latch takes the pre-tick value so a lap on a tick cycle
                // shows the time the button was seen, not one centisecond later.
                if (lap_edge_s) begin
                    if (!lap_hold_r) begin
                        lap_r      <= live_r;
                        lap_hold_r <= 1'b1;
                    end else begin
                        lap_hold_r <= 1'b0;
                    end
                end
            end
        end
    end

    assign disp_s = lap_hold_r ? lap_r : live_r;

    assign sw.CS_ONES  = disp_s[0];
    assign sw.CS_TENS  = disp_s[1];
    assign sw.SEC_ONES = disp_s[2];
    assign sw.SEC_TENS = disp_s[3];
    assign sw.MIN_ONES = disp_s[4];
    assign sw.MIN_TENS = disp_s[5];
    assign sw.RUNNING  = running_r;
    assign sw.LAP_HOLD = lap_hold_r;
    assign sw.OVERFLOW = overflow_r;

endmodule

// File: tb/tb_sw_stopwatch_counter.sv
// Bench for sw_stopwatch_counter: vector table, wrap sequence and random
// stimulus, all checked against a centisecond-count reference model.
module tb_sw_stopwatch_counter;

    localparam int N_TICK = 10;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    sw_stopwatch_counter_if bus ();

    sw_stopwatch_counter #(.CLK_PER_TICK(N_TICK), .PRE_W(4)) dut (
        .CLK   (clk),
        .RESET (rst),
        .sw    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: elapsed time as a plain centisecond count.
    int   m_total;
    int   m_lap;
    int   m_pre;
    logic m_hold;
    logic m_ovf;
    logic m_run;
    logic m_prev;

    function automatic logic [23:0] disp_of(input int t);
        int mins;
        int secs;
        int cs;
        mins = t / 6000;
        secs = (t / 100) % 60;
        cs   = t % 100;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
                4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic model_update(input logic r, input logic [1:0] m, input logic l);
        if (r) begin
            m_total = 0; m_lap = 0; m_pre = 0;
            m_hold = 1'b0; m_ovf = 1'b0; m_run = 1'b0; m_prev = 1'b0;
        end else if (m == 2'b00 || m == 2'b11) begin
            m_total = 0; m_lap = 0; m_pre = 0;
            m_hold = 1'b0; m_ovf = 1'b0; m_run = 1'b0; m_prev = l;
        end else begin
            if (l && !m_prev) begin
                if (!m_hold) begin
                    m_lap  = m_total;
                    m_hold = 1'b1;
                end else begin
                    m_hold = 1'b0;
                end
            end
            if (m == 2'b01) begin
                m_pre = m_pre + 1;
                if (m_pre == N_TICK) begin
                    m_pre   = 0;
                    m_total = m_total + 1;
                    if (m_total == 360000) begin
                        m_total = 0;
                        m_ovf   = 1'b1;
                    end
                end
            end
            m_run  = (m == 2'b01);
            m_prev = l;
        end
    endtask

    function automatic logic [26:0] dut_vec();
        return {bus.MIN_TENS, bus.MIN_ONES, bus.SEC_TENS, bus.SEC_ONES,
                bus.CS_TENS, bus.CS_ONES, bus.RUNNING, bus.LAP_HOLD, bus.OVERFLOW};
    endfunction

    task automatic check(input string name, input logic [26:0] got, input logic [26:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (disp,run,hold,ovf)", name, got, exp);
        end
    endtask

    task automatic check_model(input string name);
        check(name, dut_vec(), {disp_of(m_hold ? m_lap : m_total), m_run, m_hold, m_ovf});
    endtask

    task automatic step(input logic r, input logic [1:0] m, input logic l);
        rst           = r;
        bus.SW_S_MODE = m;
        bus.SW_L      = l;
        @(posedge clk);
        model_update(r, m, l);
        #1;
        check_model("model");
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  mode;
        logic        swl;
        int          n;
        logic [23:0] disp;
        logic        run;
        logic        hold;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [1:0] m, input logic l, input int n,
                                input logic [23:0] d, input logic run, input logic hold,
                                input logic ovf);
        vec_t v;
        v.rst = r; v.mode = m; v.swl = l; v.n = n;
        v.disp = d; v.run = run; v.hold = hold; v.ovf = ovf;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [1:0] cur_mode;
        logic       cur_l;
        logic       r;
        int         p;

        total = 0;
        bad   = 0;
        m_total = 0; m_lap = 0; m_pre = 0;
        m_hold = 1'b0; m_ovf = 1'b0; m_run = 1'b0; m_prev = 1'b0;
        rst = 1'b1;
        bus.SW_S_MODE = 2'b01;
        bus.SW_L      = 1'b0;

        // reset, first tick, first full second
        add(1'b1, 2'b01, 1'b0, 2,    24'h000000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b0, 9,    24'h000000, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b0, 1,    24'h000001, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b0, 990,  24'h000100, 1'b1, 1'b0, 1'b0);
        // stop keeps the partial prescaler count
        add(1'b0, 2'b00, 1'b0, 1,    24'h000000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b0, 995,  24'h000099, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b10, 1'b0, 500,  24'h000099, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b0, 4,    24'h000099, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b0, 1,    24'h000100, 1'b1, 1'b0, 1'b0);
        // lap edge in clear ignored, mode 11 clears
        add(1'b0, 2'b00, 1'b1, 1,    24'h000000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b1, 1,    24'h000000, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b0, 999,  24'h000100, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b11, 1'b0, 1,    24'h000000, 1'b0, 1'b0, 1'b0);
        // lap capture and release
        add(1'b0, 2'b01, 1'b0, 10,   24'h000001, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b1, 1,    24'h000001, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'b01, 1'b1, 20,   24'h000001, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'b01, 1'b0, 1,    24'h000001, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'b01, 1'b1, 1,    24'h000003, 1'b1, 1'b0, 1'b0);
        // lap edge while stopped
        add(1'b0, 2'b10, 1'b0, 1,    24'h000003, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'b10, 1'b1, 1,    24'h000003, 1'b0, 1'b1, 1'b0);
        add(1'b0, 2'b01, 1'b0, 1,    24'h000003, 1'b1, 1'b1, 1'b0);
        // reset while frozen
        add(1'b1, 2'b01, 1'b1, 1,    24'h000000, 1'b0, 1'b0, 1'b0);
        // tick and lap capture in the same cycle
        add(1'b0, 2'b01, 1'b0, 9,    24'h000000, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b1, 1,    24'h000000, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'b01, 1'b0, 1,    24'h000000, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'b01, 1'b1, 1,    24'h000001, 1'b1, 1'b0, 1'b0);
        // clear on a tick cycle wins
        add(1'b0, 2'b01, 1'b0, 7,    24'h000001, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b00, 1'b0, 1,    24'h000000, 1'b0, 1'b0, 1'b0);
        // lap at 00:03.47, release at 00:05.47
        add(1'b1, 2'b01, 1'b0, 1,    24'h000000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b0, 3470, 24'h000347, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b1, 1,    24'h000347, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'b01, 1'b0, 1998, 24'h000347, 1'b1, 1'b1, 1'b0);
        add(1'b0, 2'b01, 1'b1, 1,    24'h000547, 1'b1, 1'b0, 1'b0);
        // reset mid-count with display frozen at 00:12.34
        add(1'b0, 2'b01, 1'b0, 6870, 24'h001234, 1'b1, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b1, 1,    24'h001234, 1'b1, 1'b1, 1'b0);
        add(1'b1, 2'b01, 1'b1, 1,    24'h000000, 1'b0, 1'b0, 1'b0);

        foreach (vecs[k]) begin
            for (int c = 0; c < vecs[k].n; c++) begin
                step(vecs[k].rst, vecs[k].mode, vecs[k].swl);
            end
            check($sformatf("vec%0d", k), dut_vec(),
                  {vecs[k].disp, vecs[k].run, vecs[k].hold, vecs[k].ovf});
        end

        // Wrap: preload 59:59.99 during stop, prescaler parked at 5.
        step(1'b1, 2'b01, 1'b0);
        for (int c = 0; c < 5; c++) step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b10, 1'b0);
        force dut.live_r = 24'h595999;
        #1;
        release dut.live_r;
        m_total = 359999;
        #1;
        check("wrap_preload", dut_vec(), {24'h595999, 1'b0, 1'b0, 1'b0});
        for (int c = 0; c < 4; c++) step(1'b0, 2'b01, 1'b0);
        check("wrap_before", dut_vec(), {24'h595999, 1'b1, 1'b0, 1'b0});
        step(1'b0, 2'b01, 1'b0);
        check("wrap_tick", dut_vec(), {24'h000000, 1'b1, 1'b0, 1'b1});
        for (int c = 0; c < 10; c++) step(1'b0, 2'b01, 1'b0);
        check("wrap_continue", dut_vec(), {24'h000001, 1'b1, 1'b0, 1'b1});
        step(1'b0, 2'b00, 1'b0);
        check("wrap_clear", dut_vec(), {24'h000000, 1'b0, 1'b0, 1'b0});

        // Random modes and lap presses against the model.
        cur_mode = 2'b01;
        cur_l    = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                p = int'($urandom_range(0, 99));
                if (p < 80)      cur_mode = 2'b01;
                else if (p < 92) cur_mode = 2'b10;
                else if (p < 97) cur_mode = 2'b00;
                else             cur_mode = 2'b11;
            end
            if ($urandom_range(0, 39) == 0) cur_l = ~cur_l;
            r = ($urandom_range(0, 999) == 0);
            step(r, cur_mode, cur_l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
